// File: rtl/gate_stim_checker.sv
// gate_stim_checker: sweeps every input vector of a gate under test and checks its output
// against the selected logic function, reporting error count and first failing vector.
module gate_stim_checker #(
   parameter int N_IN   = 2,
   parameter int SETTLE = 2
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            start,
   input  logic [2:0]      op,
   output logic [N_IN-1:0] stim,
   input  logic            dut_y,
   output logic            busy,
   output logic            done,
   output logic            pass,
   output logic [N_IN:0]   err_cnt,
   output logic            first_fail_valid,
   output logic [N_IN-1:0] first_fail_vec
);
   localparam int CW = SETTLE > 1 ? $clog2(SETTLE) : 1;
   localparam logic [CW-1:0] RELOAD = CW'(SETTLE - 1);
   localparam logic [N_IN-1:0] LAST = '1;
   typedef enum logic [1:0] {IDLE, APPLY, CHECK, DONE} state_t;
   state_t          state, state_d;
   logic [CW-1:0]   cnt, cnt_d;
   logic [2:0]      op_q, op_d;
   logic [N_IN-1:0] stim_d, ffvec_d;
   logic [N_IN:0]   err_d;
   logic            ffv_d, done_d, pass_d;
   logic [7:0]      fn;
   logic            miss;
   assign busy = (state == APPLY) || (state == CHECK);
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state            <= IDLE;
         cnt              <= '0;
         op_q             <= '0;
         stim             <= '0;
         err_cnt          <= '0;
         first_fail_valid <= 1'b0;
         first_fail_vec   <= '0;
         done             <= 1'b0;
         pass             <= 1'b0;
      end else begin
         state            <= state_d;
         cnt              <= cnt_d;
         op_q             <= op_d;
         stim             <= stim_d;
         err_cnt          <= err_d;
         first_fail_valid <= ffv_d;
         first_fail_vec   <= ffvec_d;
         done             <= done_d;
         pass             <= pass_d;
      end
   end
   // op encoding indexes this table: BUF NOT AND OR NAND NOR XOR XNOR
   always_comb begin
      fn      = {~^stim, ^stim, ~|stim, ~&stim, |stim, &stim, ~stim[0], stim[0]};
      miss    = dut_y ^ fn[op_q];
      state_d = state;
      cnt_d   = cnt;
      op_d    = op_q;
      stim_d  = stim;
      err_d   = err_cnt;
      ffv_d   = first_fail_valid;
      ffvec_d = first_fail_vec;
      done_d  = done;
      pass_d  = pass;
      case (state)
         IDLE: if (start) begin
            op_d    = op;
            err_d   = '0;
            ffv_d   = 1'b0;
            ffvec_d = '0;
            done_d  = 1'b0;
            pass_d  = 1'b0;
            stim_d  = '0;
            cnt_d   = RELOAD;
            state_d = APPLY;
         end
         APPLY: begin
            state_d = cnt == '0 ? CHECK : APPLY;
            cnt_d   = cnt == '0 ? cnt : cnt - 1'b1;
         end
         CHECK: begin
            if (miss) begin
               err_d = err_cnt + 1'b1;
               if (!first_fail_valid) begin
                  ffv_d   = 1'b1;
                  ffvec_d = stim;
               end
            end
            if (stim == LAST) begin
               state_d = DONE;
               done_d  = 1'b1;
               pass_d  = err_d == '0;
            end else begin
               stim_d  = stim + 1'b1;
               cnt_d   = RELOAD;
               state_d = APPLY;
            end
         end
         default: state_d = IDLE;
      endcase
   end
endmodule

// File: tb/tb_gate_stim_checker.sv
// tb_gate_stim_checker: directed checks of gate_stim_checker on three configurations
// (N_IN=2/SETTLE=2, N_IN=1/SETTLE=2, N_IN=3/SETTLE=1) with modelled gates.
module tb_gate_stim_checker;
   logic clk = 0, rst_n = 0;
   always #5 clk = ~clk;
   int total = 0, bad = 0;

   // mode: 0 correct gate for ref op, 1 output stuck at 0, 2 buffer of stim[0]
   logic       start_a = 0, y_a, busy_a, done_a, pass_a, ffv_a;
   logic [2:0] op_a = 0, ref_a = 0, err_a;
   logic [1:0] stim_a, ffvec_a;
   int         mode_a = 0;
   logic       start_b = 0, y_b, busy_b, done_b, pass_b, ffv_b;
   logic [2:0] op_b = 0, ref_b = 0;
   logic [0:0] stim_b, ffvec_b;
   logic [1:0] err_b;
   int         mode_b = 0;
   logic       start_c = 0, y_c, busy_c, done_c, pass_c, ffv_c;
   logic [2:0] op_c = 0, ref_c = 0, stim_c, ffvec_c;
   logic [3:0] err_c;

   function automatic logic model_y(input logic [7:0] s, input int n, input logic [2:0] op);
      logic a = 1'b1, o = 1'b0, x = 1'b0;
      for (int i = 0; i < n; i++) begin
         a = a & s[i];
         o = o | s[i];
         x = x ^ s[i];
      end
      case (op)
         3'd0: return s[0];
         3'd1: return ~s[0];
         3'd2: return a;
         3'd3: return o;
         3'd4: return ~a;
         3'd5: return ~o;
         3'd6: return x;
         default: return ~x;
      endcase
   endfunction

   assign y_a = mode_a == 0 ? model_y(8'(stim_a), 2, ref_a) : mode_a == 1 ? 1'b0 : stim_a[0];
   assign y_b = mode_b == 0 ? model_y(8'(stim_b), 1, ref_b) : mode_b == 1 ? 1'b0 : stim_b[0];
   assign y_c = model_y(8'(stim_c), 3, ref_c);

   gate_stim_checker #(.N_IN(2), .SETTLE(2)) u_a (
      .clk(clk), .rst_n(rst_n), .start(start_a), .op(op_a), .stim(stim_a), .dut_y(y_a),
      .busy(busy_a), .done(done_a), .pass(pass_a), .err_cnt(err_a),
      .first_fail_valid(ffv_a), .first_fail_vec(ffvec_a));
   gate_stim_checker #(.N_IN(1), .SETTLE(2)) u_b (
      .clk(clk), .rst_n(rst_n), .start(start_b), .op(op_b), .stim(stim_b), .dut_y(y_b),
      .busy(busy_b), .done(done_b), .pass(pass_b), .err_cnt(err_b),
      .first_fail_valid(ffv_b), .first_fail_vec(ffvec_b));
   gate_stim_checker #(.N_IN(3), .SETTLE(1)) u_c (
      .clk(clk), .rst_n(rst_n), .start(start_c), .op(op_c), .stim(stim_c), .dut_y(y_c),
      .busy(busy_c), .done(done_c), .pass(pass_c), .err_cnt(err_c),
      .first_fail_valid(ffv_c), .first_fail_vec(ffvec_c));

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic run_a(output int cyc);
      @(negedge clk) start_a = 1;
      @(negedge clk) start_a = 0;
      chk("a_clr_done", 32'(done_a), 0);
      chk("a_clr_err", 32'(err_a), 0);
      chk("a_clr_ffv", 32'(ffv_a), 0);
      cyc = 0;
      while (busy_a && cyc < 200) begin
         cyc++;
         @(negedge clk);
      end
   endtask

   task automatic run_b(output int cyc, output logic [15:0] trace);
      @(negedge clk) start_b = 1;
      @(negedge clk) start_b = 0;
      cyc = 0;
      trace = '0;
      while (busy_b && cyc < 200) begin
         if (cyc < 16) trace[cyc] = stim_b[0];
         cyc++;
         @(negedge clk);
      end
   endtask

   task automatic run_c(input bit poke, output int cyc);
      @(negedge clk) start_c = 1;
      @(negedge clk) start_c = 0;
      cyc = 0;
      while (busy_c && cyc < 200) begin
         if (poke && cyc == 5) begin
            op_c = 0;
            start_c = 1;
         end else start_c = 0;
         cyc++;
         @(negedge clk);
      end
      start_c = 0;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int cyc;
      logic [15:0] tr;
      repeat (2) @(negedge clk);
      chk("rst_stim", 32'(stim_a), 0);
      chk("rst_busy", 32'(busy_a), 0);
      chk("rst_done", 32'(done_a), 0);
      chk("rst_pass", 32'(pass_a), 0);
      chk("rst_err", 32'(err_a), 0);
      chk("rst_ffv", 32'(ffv_a), 0);
      chk("rst_ffvec", 32'(ffvec_a), 0);
      rst_n = 1;
      // NOT, N_IN=1, correct gate: stim 0 for three cycles then 1 for three
      op_b = 1; ref_b = 1; mode_b = 0;
      run_b(cyc, tr);
      chk("not_busy_cyc", cyc, 6);
      chk("not_trace", 32'(tr[5:0]), 32'b111000);
      chk("not_done", 32'(done_b), 1);
      chk("not_err", 32'(err_b), 0);
      chk("not_pass", 32'(pass_b), 1);
      chk("not_ffv", 32'(ffv_b), 0);
      // NOT expected but gate wired as buffer
      mode_b = 2;
      run_b(cyc, tr);
      chk("buf_err", 32'(err_b), 2);
      chk("buf_ffvec", 32'(ffvec_b), 0);
      chk("buf_ffv", 32'(ffv_b), 1);
      chk("buf_pass", 32'(pass_b), 0);
      // AND with output stuck at 0
      op_a = 2; ref_a = 2; mode_a = 1;
      run_a(cyc);
      chk("and_busy_cyc", cyc, 12);
      chk("and_err", 32'(err_a), 1);
      chk("and_ffvec", 32'(ffvec_a), 3);
      chk("and_ffv", 32'(ffv_a), 1);
      chk("and_pass", 32'(pass_a), 0);
      chk("and_done", 32'(done_a), 1);
      // start while in DONE is ignored
      start_a = 1;
      @(negedge clk) start_a = 0;
      chk("done_start_busy", 32'(busy_a), 0);
      chk("done_start_done", 32'(done_a), 1);
      chk("done_start_err", 32'(err_a), 1);
      // back-to-back correct run clears results at start
      mode_a = 0;
      run_a(cyc);
      chk("b2b_err", 32'(err_a), 0);
      chk("b2b_pass", 32'(pass_a), 1);
      chk("b2b_ffv", 32'(ffv_a), 0);
      chk("b2b_done", 32'(done_a), 1);
      // XOR, N_IN=3, SETTLE=1, with op change and start pulse mid-sweep
      op_c = 6; ref_c = 6;
      run_c(1, cyc);
      chk("xor_busy_cyc", cyc, 16);
      chk("xor_err", 32'(err_c), 0);
      chk("xor_pass", 32'(pass_c), 1);
      chk("xor_done", 32'(done_c), 1);
      // reset during vector 2 of an OR sweep
      op_a = 3; ref_a = 3; mode_a = 0;
      @(negedge clk) start_a = 1;
      @(negedge clk) start_a = 0;
      for (int i = 0; i < 50 && stim_a != 2; i++) @(negedge clk);
      chk("or_reach_v2", 32'(stim_a), 2);
      #2 rst_n = 0;
      #1;
      chk("mid_rst_stim", 32'(stim_a), 0);
      chk("mid_rst_busy", 32'(busy_a), 0);
      chk("mid_rst_done", 32'(done_a), 0);
      chk("mid_rst_err", 32'(err_a), 0);
      chk("mid_rst_pass", 32'(pass_a), 0);
      @(negedge clk) rst_n = 1;
      repeat (3) @(negedge clk);
      chk("post_rst_idle", 32'(busy_a), 0);
      chk("post_rst_nodone", 32'(done_a), 0);
      run_a(cyc);
      chk("or_busy_cyc", cyc, 12);
      chk("or_err", 32'(err_a), 0);
      chk("or_pass", 32'(pass_a), 1);
      chk("or_stim_hold", 32'(stim_a), 3);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/gate_stim_checker.md
Name: gate_stim_checker

Overview:
- Self-checking stimulus sequencer for the basic-gate library.
- Sits directly upstream of a gate under test and drives its inputs. It also takes back the gate's output and checks it against the expected logic function.
- Sweeps every input combination and counts mismatches. It reports pass/fail and the first failing vector.
- Replaces hand-written per-gate stimulus sequences with one reusable sequential block.

Parameters:
- N_IN, 2, number of gate inputs driven; legal 1..8.
- SETTLE, 2, cycles each vector is held before the output is sampled; legal >= 1.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- start  input  1  single-cycle run request; honoured only in IDLE.
- op  input  3  expected-function select, latched at start: 0 BUF, 1 NOT, 2 AND, 3 OR, 4 NAND, 5 NOR, 6 XOR, 7 XNOR.
- stim  output  N_IN  registered vector driven to the gate inputs.
- dut_y  input  1  gate output, combinational from stim.
- busy  output  1  high while a sweep is in progress.
- done  output  1  high from sweep end until the next accepted start.
- pass  output  1  valid when done; high iff err_cnt == 0.
- err_cnt  output  N_IN+1  number of mismatching vectors in the last sweep.
- first_fail_valid  output  1  high once any mismatch has been recorded in the current sweep.
- first_fail_vec  output  N_IN  stim value of the first mismatch.

Behaviour:
- Reset (async assert, sync release):
  - Outputs: stim=0, busy=0, done=0, pass=0, err_cnt=0, first_fail_valid=0, first_fail_vec=0.
  - Internal: state=IDLE, settle counter=0, latched op=0.
- FSM states: IDLE, APPLY, CHECK, DONE.
- IDLE:
  - On start=1: latch op; clear err_cnt, first_fail_*, done and pass; set stim=0; load settle counter with SETTLE-1; go to APPLY.
- APPLY:
  - busy=1; stim held stable.
  - If counter==0, go to CHECK; otherwise decrement the counter.
  - APPLY therefore lasts exactly SETTLE cycles per vector.
- CHECK (1 cycle), busy=1:
  - Compare dut_y with exp(stim, op_latched).
  - On mismatch: err_cnt += 1. If first_fail_valid==0, also set first_fail_vec=stim and first_fail_valid=1.
  - If stim == 2^N_IN-1, go to DONE.
  - Otherwise stim += 1, reload the counter with SETTLE-1, and go to APPLY.
- DONE (1 cycle):
  - busy=0, done=1, pass=(err_cnt==0).
  - stim is held at the last vector.
  - Go to IDLE; done, pass and err_cnt remain held in IDLE.
- Expected function exp:
  - BUF = stim[0]; NOT = ~stim[0].
  - AND/OR/XOR and their complements are reductions over all N_IN bits of stim.
  - If N_IN=1, the reductions reduce to BUF/NOT of stim[0].
- Timing:
  - Each vector occupies SETTLE+1 cycles.
  - busy is high for exactly 2^N_IN*(SETTLE+1) cycles, starting the cycle after start is sampled.
  - done rises the cycle after the final CHECK.
- Arithmetic:
  - err_cnt max value is 2^N_IN, which fits N_IN+1 bits; no saturation needed.
  - stim never wraps during a sweep.
- Boundary conditions:
  - start while busy: ignored; no restart, no counter clear.
  - op changes mid-sweep: ignored; the latched op is used.
  - start in IDLE with done=1: new sweep begins; done, pass, err_cnt and first_fail_* clear on the same edge that enters APPLY.
  - start asserted in DONE: ignored.
  - dut_y is sampled only in CHECK; glitches during APPLY are don't-care.
  - rst_n low mid-sweep: immediate return to reset values, stim=0; no done pulse; a new start is required.

Test Plan:
- NOT gate, N_IN=1, SETTLE=2, correct DUT:
  - start -> stim=0 for 3 cycles, then stim=1 for 3 cycles.
  - busy high 6 cycles; done next cycle; err_cnt=0, pass=1, first_fail_valid=0.
- AND gate, N_IN=2, op=2, dut_y stuck at 0:
  - Sweep 00..11 -> err_cnt=1, first_fail_vec=2'b11, pass=0.
- NOT gate, op=1, dut_y = stim[0] (BUF wired by mistake):
  - -> err_cnt=2, first_fail_vec=0, first_fail_valid=1, pass=0.
- XOR, N_IN=3, SETTLE=1, correct DUT:
  - busy for 16 cycles -> err_cnt=0, pass=1.
  - Change op to 0 and pulse start mid-sweep -> no effect on the result or the cycle count.
- Reset mid-sweep on an OR sweep, N_IN=2:
  - Assert rst_n=0 during vector 2 -> all outputs zero asynchronously.
  - Release and start again -> full 4-vector sweep completes normally.
- Back-to-back runs:
  - After a failing run (err_cnt=1), start a correct run -> err_cnt, first_fail_* and done clear at start.
  - Final err_cnt=0, pass=1.
